// File: rtl/tlp_slave_tx.sv
// tlp_slave_tx: receiving end of the TLP request interface.
// Grants one requesting master and latches its header fields. The TLP is then
// streamed out as two 64-bit header beats followed by the payload beats,
// through a small registered skid buffer toward the PCIe core TX port.
// The tlp_interface members are flattened into plain ports.
// Optional build macro: TLP_SLAVE_TX_STATS_EN adds stat_tlp_cnt / stat_dw_cnt.
module tlp_slave_tx #(
    parameter logic [15:0] COMPLETER_ID = 16'h0000,
    parameter int          SKID_DEPTH   = 2
) (
    input  logic        sysclk,
    input  logic        sysrst,
    input  logic        req_to_send,
    output logic        grant,
    output logic        dst_rdy_n,
    input  logic        src_rdy_n,
    input  logic [6:0]  fmt_type,
    input  logic [9:0]  length_in_dw,
    input  logic [61:0] address,
    input  logic [7:0]  ldwbe_fdwbe,
    input  logic [1:0]  attr,
    input  logic [23:0] transaction_id,
    input  logic [11:0] byte_count,
    input  logic [6:0]  lower_address,
    input  logic [63:0] data,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready
`ifdef TLP_SLAVE_TX_STATS_EN
    ,
    output logic [31:0] stat_tlp_cnt,
    output logic [31:0] stat_dw_cnt
`endif
);

    // state | meaning
    // IDLE  | wait for a request with the skid buffer drained
    // GRANT | grant high for one cycle, header fields latched
    // HDR0  | push header beat 0
    // HDR1  | push header beat 1 (ends the TLP when there is no payload)
    // DATA  | accept payload beats from the master
    typedef enum logic [2:0] {IDLE, GRANT, HDR0, HDR1, DATA} state_t;

    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(SKID_DEPTH);

    state_t        state, state_nxt;
    logic [6:0]    r_fmt;
    logic [9:0]    r_len;
    logic [61:0]   r_addr;
    logic [7:0]    r_be;
    logic [1:0]    r_attr;
    logic [23:0]   r_tid;
    logic [11:0]   r_bc;
    logic [6:0]    r_la;
    logic [9:0]    beat_cnt;

    logic [63:0]   e_data [SKID_DEPTH];
    logic [7:0]    e_keep [SKID_DEPTH];
    logic          e_last [SKID_DEPTH];
    logic [CW-1:0] count, cnt_nxt, wr_idx;
    logic          tvalid;

    logic          is_cpl, free, pop, push, data_xfer, last_beat;
    logic [63:0]   hdr0, hdr1, push_data;
    logic [7:0]    push_keep;
    logic          push_last;

    assign is_cpl    = (r_fmt[4:0] == 5'b01010);
    assign free      = (count < DEPTH_C);
    assign pop       = tvalid && m_tready;
    assign data_xfer = (state == DATA) && !src_rdy_n && !dst_rdy_n;
    assign last_beat = (beat_cnt == 10'd0);
    assign hdr0      = {1'b0, r_fmt, 1'b0, 3'b0, 4'b0, 2'b00, r_attr, 2'b00, r_len,
                        is_cpl ? {COMPLETER_ID, 4'b0, r_bc} : {r_tid, r_be}};
    assign hdr1      = is_cpl ? {r_tid, 1'b0, r_la, 32'h0} : {r_addr, 2'b00};
    assign cnt_nxt   = count + CW'(push) - CW'(pop);
    assign wr_idx    = pop ? count - CW'(1) : count;

    assign m_tdata   = e_data[0];
    assign m_tkeep   = e_keep[0];
    assign m_tlast   = e_last[0];
    assign m_tvalid  = tvalid;

    // Select the beat to push this cycle and the next FSM state
    always_comb begin
        push      = 1'b0;
        push_data = 64'h0;
        push_keep = 8'h00;
        push_last = 1'b0;
        state_nxt = state;
        case (state)
            IDLE:  if (req_to_send && count == '0) state_nxt = GRANT;
            GRANT: state_nxt = HDR0;
            HDR0: begin
                if (free) begin
                    push      = 1'b1;
                    push_data = hdr0;
                    push_keep = 8'hFF;
                    state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (free) begin
                    push      = 1'b1;
                    push_data = hdr1;
                    push_last = !r_fmt[6];
                    push_keep = (!r_fmt[6] && is_cpl) ? 8'hF0 : 8'hFF;
                    state_nxt = r_fmt[6] ? DATA : IDLE;
                end
            end
            DATA: begin
                if (data_xfer) begin
                    push      = 1'b1;
                    push_data = data;
                    push_last = last_beat;
                    push_keep = (last_beat && r_len[0]) ? 8'h0F : 8'hFF;
                    if (last_beat) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, latched header fields, payload down-counter and registered handshakes
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state     <= IDLE;
            grant     <= 1'b0;
            dst_rdy_n <= 1'b1;
            r_fmt     <= '0;
            r_len     <= '0;
            r_addr    <= '0;
            r_be      <= '0;
            r_attr    <= '0;
            r_tid     <= '0;
            r_bc      <= '0;
            r_la      <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= (state_nxt == GRANT);
            dst_rdy_n <= !((state_nxt == DATA) && (cnt_nxt < DEPTH_C));
            if (state == GRANT) begin
                r_fmt    <= fmt_type;
                r_len    <= length_in_dw;
                r_addr   <= address;
                r_be     <= ldwbe_fdwbe;
                r_attr   <= attr;
                r_tid    <= transaction_id;
                r_bc     <= byte_count;
                r_la     <= lower_address;
                // beats - 1; a zero length field means 1024 DW, i.e. 512 beats
                beat_cnt <= (length_in_dw == 10'd0) ? 10'd511 : (length_in_dw - 10'd1) >> 1;
            end else if (data_xfer && !last_beat) begin
                beat_cnt <= beat_cnt - 10'd1;
            end
        end
    end

    // Shift-register skid buffer; entry 0 is the registered output beat
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            count  <= '0;
            tvalid <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                e_data[i] <= '0;
                e_keep[i] <= '0;
                e_last[i] <= 1'b0;
            end
        end else begin
            count  <= cnt_nxt;
            tvalid <= (cnt_nxt != '0);
            for (int i = 0; i < SKID_DEPTH; i++) begin
                if (push && (wr_idx == CW'(i))) begin
                    e_data[i] <= push_data;
                    e_keep[i] <= push_keep;
                    e_last[i] <= push_last;
                end else if (pop && (i < SKID_DEPTH - 1)) begin
                    e_data[i] <= e_data[(i + 1) % SKID_DEPTH];
                    e_keep[i] <= e_keep[(i + 1) % SKID_DEPTH];
                    e_last[i] <= e_last[(i + 1) % SKID_DEPTH];
                end
            end
        end
    end

`ifdef TLP_SLAVE_TX_STATS_EN
    // Count completed TLPs and their DW length when the last beat leaves
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            stat_tlp_cnt <= '0;
            stat_dw_cnt  <= '0;
        end else if (pop && e_last[0]) begin
            stat_tlp_cnt <= stat_tlp_cnt + 32'd1;
            stat_dw_cnt  <= stat_dw_cnt + {21'd0, (r_len == 10'd0), r_len};
        end
    end
`endif

endmodule
